// File: rtl/register_file_pkg.sv
// register_file_pkg: shared defaults, bypass encodings and clog2 helper for the register file
package register_file_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int BYP_NEW = 1;
    localparam int BYP_OLD = 0;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write/read/clear bus of the register file; perr exists only with REGFILE_PARITY_EN
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);
    logic             wr;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] d;
    logic             rd;
    logic [AW-1:0]    ra;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             hit;
`ifdef REGFILE_PARITY_EN
    logic             perr;
    modport master (output wr, wa, d, rd, ra, clr, input q, q_valid, hit, perr);
    modport slave  (input wr, wa, d, rd, ra, clr, output q, q_valid, hit, perr);
`else
    modport master (output wr, wa, d, rd, ra, clr, input q, q_valid, hit);
    modport slave  (input wr, wa, d, rd, ra, clr, output q, q_valid, hit);
`endif
endinterface

// File: rtl/register_file_entry.sv
// regfile_entry: one stored word with its valid bit (and parity bit under REGFILE_PARITY_EN)
module regfile_entry
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
`ifdef REGFILE_PARITY_EN
    output logic             par,
`endif
    output logic [WIDTH-1:0] word,
    output logic             valid
);
    // word and valid; a write in the same cycle as clr leaves the entry valid
    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            valid <= 1'b0;
        end else begin
            if (we) word <= d;
            valid <= we | (valid & ~clr);
        end
    end
`ifdef REGFILE_PARITY_EN
    // even parity of the written data, kept alongside the word
    always_ff @(posedge clk) begin
        par <= rst ? 1'b0 : we ? ^d : par;
    end
`endif
endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH bank with registered read, valid tracking and bulk clear; parity via REGFILE_PARITY_EN
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BYPASS = BYP_NEW
) (
    input logic           clk,
    input logic           rst,
    register_file_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] valids;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             byp;
`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0] pars;
    logic             rpar;
`endif
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        regfile_entry #(.WIDTH(WIDTH)) u_ent (
            .clk   (clk),
            .rst   (rst),
            .we    (bus.wr && bus.wa == AW'(i)),
            .clr   (bus.clr),
            .d     (bus.d),
`ifdef REGFILE_PARITY_EN
            .par   (pars[i]),
`endif
            .word  (words[i]),
            .valid (valids[i])
        );
    end
    // read mux; addresses with no entry read as zero and invalid
    always_comb begin
        rdata  = '0;
        rvalid = 1'b0;
`ifdef REGFILE_PARITY_EN
        rpar   = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.ra == AW'(i)) begin
                rdata  = words[i];
                rvalid = valids[i];
`ifdef REGFILE_PARITY_EN
                rpar   = pars[i];
`endif
            end
        end
    end
    assign byp = (BYPASS == BYP_NEW) && bus.wr && bus.wa == bus.ra && int'(bus.ra) < DEPTH;
    // output registers: q/hit hold between reads, q_valid pulses per read
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.q       <= '0;
            bus.hit     <= 1'b0;
            bus.q_valid <= 1'b0;
        end else begin
            bus.q_valid <= bus.rd;
            if (bus.rd) begin
                bus.q   <= byp ? bus.d : rdata;
                bus.hit <= byp | rvalid;
            end
        end
    end
`ifdef REGFILE_PARITY_EN
    // parity error flag; bypassed and out-of-range reads carry no stored parity
    always_ff @(posedge clk) begin
        bus.perr <= rst ? 1'b0 : bus.rd ? (!byp && (rpar != ^rdata)) : bus.perr;
    end
`endif
endmodule
